obstacle_gen: RTL and testbench

OBSTACLE_GEN -- requirements
Module: obstacle_gen

---
 rtl/game_pkg.sv | 27 ++
 rtl/col_fifo.sv | 58 +++++
 rtl/obstacle_gen.sv | 146 ++++++++++++++
 tb/tb_obstacle_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Purpose: shared widths, LFSR constants and FSM encoding for the obstacle generator.
// Latency: none; declarations plus one pure helper function.
// Backpressure: none.
package game_pkg;

  localparam int HEIGHT_W   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int COUNT_W    = 14;

  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;
  localparam logic [15:0]        LFSR_TAPS    = 16'hB400;
  localparam logic [15:0]        DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/col_fifo.sv
// Purpose: 4-entry x 2-bit synchronous column FIFO with flush, full and empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over both.
module col_fifo
  import game_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [HEIGHT_W-1:0]   i_dat,
  input  logic                  i_pop,
  output logic [HEIGHT_W-1:0]   o_dat,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [FIFO_CNT_W-1:0] o_count
);

  logic [HEIGHT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_wr_ptr;
  logic [FIFO_PTR_W-1:0] r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;

  // Head is forced to zero when empty so the output is defined during reset.
  assign o_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written only on accepted pushes, needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + FIFO_CNT_W'(1);
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - FIFO_CNT_W'(1);
    end
  end

endmodule

// File: rtl/obstacle_gen.sv
// Purpose: pseudo-random pipe/gap column generator feeding a 4-deep column FIFO.
// Latency: start in cycle N -> first column valid at N+2, FIFO full and primed at N+5.
// Backpressure: col_ready low holds the head stable; generation pauses while the FIFO is full.
module obstacle_gen
  import game_pkg::*;
#(
  parameter int MIN_GAP = 3,
  parameter int MAX_RUN = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [15:0]         seed,
  input  logic                col_ready,
  output logic                col_valid,
  output logic [HEIGHT_W-1:0] col_height,
  output logic                primed,
  output logic [COUNT_W-1:0]  col_count
);

  localparam logic [3:0] LP_MIN_GAP = 4'(MIN_GAP);
  localparam logic [1:0] LP_MAX_RUN = 2'(MAX_RUN);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_gen_en;
  logic [15:0]           r_lfsr;
  logic [HEIGHT_W-1:0]   r_last_h;
  logic [1:0]            r_run_cnt;
  logic [3:0]            r_gap_cnt;
  logic [HEIGHT_W-1:0]   w_emit_h;
  logic [1:0]            w_run_nxt;
  logic [3:0]            w_gap_nxt;
  logic [3:0]            w_gap_inc;
  logic                  r_primed;
  logic [COUNT_W-1:0]    r_col_count;
  logic                  w_full;
  logic                  w_empty;
  logic [FIFO_CNT_W-1:0] w_fifo_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_will_full;

  // A start cycle flushes everything, so it neither pushes nor pops.
  assign w_push      = w_gen_en && !w_full && !start;
  assign w_pop       = col_valid && col_ready && !start;
  assign w_will_full = w_push && !w_pop && (w_fifo_count == FIFO_CNT_W'(FIFO_DEPTH - 1));
  assign col_valid   = !w_empty;
  assign primed      = r_primed;
  assign col_count   = r_col_count;
  assign w_gap_inc   = (r_gap_cnt == 4'hF) ? 4'hF : r_gap_cnt + 4'd1;

  col_fifo u_col_fifo (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_flush  (start),
    .i_push   (w_push),
    .i_dat    (w_emit_h),
    .i_pop    (w_pop),
    .o_dat    (col_height),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: start restarts from any state; FILL ends on the push that fills the FIFO.
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: if (w_will_full) w_state_nxt = ST_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // FSM outputs: the generator runs in FILL and RUN only.
  always_comb begin
    w_gen_en = (r_state != ST_IDLE);
  end

  // Pattern rules, highest priority first: extend pipe, close pipe, enforce gap, open pipe, idle.
  always_comb begin
    w_emit_h  = '0;
    w_run_nxt = r_run_cnt;
    w_gap_nxt = r_gap_cnt;
    if ((r_last_h != '0) && (r_run_cnt < LP_MAX_RUN) && r_lfsr[2]) begin
      w_emit_h  = r_last_h;
      w_run_nxt = r_run_cnt + 2'd1;
    end else if (r_last_h != '0) begin
      w_gap_nxt = 4'd1;
      w_run_nxt = '0;
    end else if (r_gap_cnt < LP_MIN_GAP) begin
      w_gap_nxt = w_gap_inc;
    end else if (r_lfsr[1:0] != 2'b00) begin
      w_emit_h  = r_lfsr[1:0];
      w_run_nxt = 2'd1;
      w_gap_nxt = '0;
    end else begin
      w_gap_nxt = w_gap_inc;
    end
  end

  // Generator state: LFSR and pattern counters advance once per pushed column.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr    <= DEFAULT_SEED;
      r_last_h  <= '0;
      r_run_cnt <= '0;
      r_gap_cnt <= '0;
    end else if (start) begin
      r_lfsr    <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
      r_last_h  <= '0;
      r_run_cnt <= '0;
      r_gap_cnt <= '0;
    end else if (w_push) begin
      r_lfsr    <= lfsr_step(r_lfsr);
      r_last_h  <= w_emit_h;
      r_run_cnt <= w_run_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Primed flag and saturating accepted-column counter, both cleared by start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_primed    <= 1'b0;
      r_col_count <= '0;
    end else if (start) begin
      r_primed    <= 1'b0;
      r_col_count <= '0;
    end else begin
      if (w_will_full) r_primed <= 1'b1;
      if (w_pop && (r_col_count != COUNT_MAX)) r_col_count <= r_col_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_obstacle_gen.sv
// Purpose: self-checking bench for obstacle_gen against a column-sequence reference model.
// Latency: checks start/fill timing cycle by cycle; streams compare popped heights in order.
// Backpressure: col_ready is randomized and stalls must hold the head stable.
module tb_obstacle_gen;

  localparam int TB_MIN_GAP = 3;
  localparam int TB_MAX_RUN = 2;
  localparam int CNT_SAT    = 16383;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [15:0] seed;
  logic        col_ready;
  logic        col_valid;
  logic [1:0]  col_height;
  logic        primed;
  logic [13:0] col_count;

  int checks;
  int errors;

  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic [1:0] save_q[$];

  obstacle_gen #(.MIN_GAP(TB_MIN_GAP), .MAX_RUN(TB_MAX_RUN)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .seed       (seed),
    .col_ready  (col_ready),
    .col_valid  (col_valid),
    .col_height (col_height),
    .primed     (primed),
    .col_count  (col_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: the ordered list of heights the generator produces after a start.
  task automatic build_model(input logic [15:0] s_seed, input int n);
    logic [15:0] s;
    int lh, run, gap, h;
    exp_q.delete();
    s = (s_seed == 16'h0000) ? 16'hACE1 : s_seed;
    lh = 0; run = 0; gap = 0;
    for (int i = 0; i < n; i++) begin
      if (lh != 0 && run < TB_MAX_RUN && s[2]) begin
        h = lh; run = run + 1;
      end else if (lh != 0) begin
        h = 0; gap = 1; run = 0;
      end else if (gap < TB_MIN_GAP) begin
        h = 0; gap = (gap < 15) ? gap + 1 : 15;
      end else if (s[1:0] != 2'b00) begin
        h = int'(s[1:0]); run = 1; gap = 0;
      end else begin
        h = 0; gap = (gap < 15) ? gap + 1 : 15;
      end
      lh = h;
      exp_q.push_back(2'(h));
      if (s[0]) s = (s >> 1) ^ 16'hB400;
      else      s = s >> 1;
    end
  endtask

  // Structural properties of the observed stream: pipe widths and gap widths.
  task automatic check_rules(input string name);
    int run, gap, max_run, min_gap, pipes;
    run = 0; gap = 0; max_run = 0; min_gap = 1000; pipes = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i] != 2'd0) begin
        if (run == 0) begin
          pipes++;
          if (gap < min_gap) min_gap = gap;
        end
        run++;
        if (run > max_run) max_run = run;
        gap = 0;
      end else begin
        run = 0;
        gap++;
      end
    end
    checks++;
    if (max_run > TB_MAX_RUN) begin
      errors++; $display("FAIL %s_max_run got %0d want <= %0d", name, max_run, TB_MAX_RUN);
    end
    checks++;
    if (min_gap < TB_MIN_GAP) begin
      errors++; $display("FAIL %s_min_gap got %0d want >= %0d", name, min_gap, TB_MIN_GAP);
    end
    checks++;
    if (pipes == 0) begin
      errors++; $display("FAIL %s_pipes got %0d want > 0", name, pipes);
    end
  endtask

  // Start with a seed, pop ncols columns under random col_ready, compare against the model.
  task automatic test_stream(input string name, input logic [15:0] s_seed, input int ncols,
                             input int ready_pct);
    int hs, cyc, exp_cnt;
    bit quiet, prev_stall;
    logic [1:0] prev_h;
    obs_q.delete();
    @(posedge clk); #1;
    start = 1'b1; seed = s_seed; col_ready = 1'($urandom_range(1));
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; cyc = 0; quiet = 0; prev_stall = 0; prev_h = '0;
    while (hs < ncols && cyc < ncols * 4 + 100) begin
      col_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (!quiet) begin
        exp_cnt = (hs > CNT_SAT) ? CNT_SAT : hs;
        checks++;
        if (int'(col_count) !== exp_cnt) begin
          errors++; quiet = 1;
          $display("FAIL %s_count cyc=%0d got %0d want %0d", name, cyc, col_count, exp_cnt);
        end
      end
      if (prev_stall && !quiet) begin
        checks++;
        if (col_valid !== 1'b1 || col_height !== prev_h) begin
          errors++; quiet = 1;
          $display("FAIL %s_stall_hold cyc=%0d got v=%0b h=%0d want v=1 h=%0d",
                   name, cyc, col_valid, col_height, prev_h);
        end
      end
      if (col_valid && col_ready) begin
        obs_q.push_back(col_height);
        hs++;
      end
      prev_stall = col_valid && !col_ready;
      prev_h = col_height;
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (hs != ncols) begin
      errors++; $display("FAIL %s_timeout got %0d cols want %0d", name, hs, ncols);
    end
    col_ready = 1'b0;
    @(negedge clk);
    exp_cnt = (hs > CNT_SAT) ? CNT_SAT : hs;
    checks++;
    if (int'(col_count) !== exp_cnt) begin
      errors++; $display("FAIL %s_final_count got %0d want %0d", name, col_count, exp_cnt);
    end
    build_model(s_seed, hs);
    for (int i = 0; i < hs; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_height idx=%0d got %0d want %0d", name, i, obs_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit quiet;
    resetn = 1'b0; start = 1'b0; seed = 16'h0000; col_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (col_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", col_valid); end
    checks++;
    if (col_height !== 2'd0) begin errors++; $display("FAIL rst_height got %0d want 0", col_height); end
    checks++;
    if (primed !== 1'b0) begin errors++; $display("FAIL rst_primed got %0b want 0", primed); end
    checks++;
    if (col_count !== 14'd0) begin errors++; $display("FAIL rst_count got %0d want 0", col_count); end
    @(posedge clk); #1;
    resetn = 1'b1; col_ready = 1'b1;
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!quiet) begin
        checks++;
        if (col_valid !== 1'b0 || col_count !== 14'd0 || primed !== 1'b0) begin
          errors++; quiet = 1;
          $display("FAIL idle_no_start k=%0d got v=%0b cnt=%0d p=%0b want v=0 cnt=0 p=0",
                   k, col_valid, col_count, primed);
        end
      end
    end
  endtask

  task automatic test_fill_stall();
    int n, cyc;
    @(posedge clk); #1;
    start = 1'b1; seed = 16'h1234; col_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (col_valid !== 1'(k >= 2)) begin
        errors++; $display("FAIL fill_valid N+%0d got %0b want %0b", k, col_valid, k >= 2);
      end
      checks++;
      if (primed !== 1'(k >= 5)) begin
        errors++; $display("FAIL fill_primed N+%0d got %0b want %0b", k, primed, k >= 5);
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (col_valid !== 1'b1 || col_height !== 2'd0) begin
        errors++; $display("FAIL stall_head k=%0d got v=%0b h=%0d want v=1 h=0", k, col_valid, col_height);
      end
    end
    build_model(16'h1234, 8);
    @(posedge clk); #1;
    col_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 40) begin
      @(negedge clk);
      if (col_valid) begin
        checks++;
        if (col_height !== exp_q[n]) begin
          errors++; $display("FAIL fill_pop idx=%0d got %0d want %0d", n, col_height, exp_q[n]);
        end
        if (n < 3) begin
          checks++;
          if (col_height !== 2'd0) begin
            errors++; $display("FAIL fill_first_zero idx=%0d got %0d want 0", n, col_height);
          end
        end
        n++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    col_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (col_count !== 14'd8 || n != 8) begin
      errors++; $display("FAIL fill_pop_count got cnt=%0d pops=%0d want 8", col_count, n);
    end
  endtask

  task automatic test_seed_zero();
    int mism;
    test_stream("seed0", 16'h0000, 1000, 70);
    save_q = obs_q;
    check_rules("seed0");
    test_stream("seedace1", 16'hACE1, 1000, 70);
    checks++;
    if (save_q.size() != obs_q.size()) begin
      errors++; $display("FAIL seed_eq_size got %0d want %0d", save_q.size(), obs_q.size());
    end
    mism = -1;
    for (int i = 0; i < save_q.size() && i < obs_q.size(); i++) begin
      if (save_q[i] !== obs_q[i]) begin mism = i; break; end
    end
    checks++;
    if (mism != -1) begin
      errors++; $display("FAIL seed_eq_seq first diff idx got %0d want -1", mism);
    end
  endtask

  task automatic test_restart();
    int n, cyc;
    test_stream("pre_restart", 16'h5A5A, 50, 60);
    @(posedge clk); #1;
    col_ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (primed !== 1'b1 || col_valid !== 1'b1 || col_count !== 14'd50) begin
      errors++; $display("FAIL restart_pre got p=%0b v=%0b cnt=%0d want p=1 v=1 cnt=50",
                         primed, col_valid, col_count);
    end
    @(posedge clk); #1;
    start = 1'b1; seed = 16'h0F0F; col_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; col_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (col_valid !== 1'(k >= 2)) begin
        errors++; $display("FAIL restart_valid N+%0d got %0b want %0b", k, col_valid, k >= 2);
      end
      checks++;
      if (primed !== 1'(k >= 5)) begin
        errors++; $display("FAIL restart_primed N+%0d got %0b want %0b", k, primed, k >= 5);
      end
      checks++;
      if (col_count !== 14'd0) begin
        errors++; $display("FAIL restart_count N+%0d got %0d want 0", k, col_count);
      end
    end
    build_model(16'h0F0F, 12);
    @(posedge clk); #1;
    col_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 12 && cyc < 60) begin
      @(negedge clk);
      if (col_valid) begin
        checks++;
        if (col_height !== exp_q[n]) begin
          errors++; $display("FAIL restart_pop idx=%0d got %0d want %0d", n, col_height, exp_q[n]);
        end
        n++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    col_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (col_count !== 14'd12 || n != 12) begin
      errors++; $display("FAIL restart_pop_count got cnt=%0d pops=%0d want 12", col_count, n);
    end
  endtask

  task automatic test_reset_mid_run();
    bit quiet;
    test_stream("pre_reset", 16'hBEEF, 30, 80);
    @(posedge clk); #1;
    col_ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (primed !== 1'b1 || col_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got p=%0b v=%0b want p=1 v=1", primed, col_valid);
    end
    @(posedge clk); #5;
    resetn = 1'b0;
    #1;
    checks++;
    if (col_valid !== 1'b0 || col_height !== 2'd0 || primed !== 1'b0 || col_count !== 14'd0) begin
      errors++; $display("FAIL midrst_async got v=%0b h=%0d p=%0b cnt=%0d want all 0",
                         col_valid, col_height, primed, col_count);
    end
    @(negedge clk); #2;
    resetn = 1'b1; col_ready = 1'b1;
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!quiet) begin
        checks++;
        if (col_valid !== 1'b0 || col_count !== 14'd0 || primed !== 1'b0) begin
          errors++; quiet = 1;
          $display("FAIL midrst_idle k=%0d got v=%0b cnt=%0d p=%0b want v=0 cnt=0 p=0",
                   k, col_valid, col_count, primed);
        end
      end
    end
    test_stream("post_reset", 16'hBEEF, 40, 50);
  endtask

  task automatic test_long_run();
    logic [15:0] lseed;
    lseed = 16'($urandom_range(65535, 1));
    test_stream("long", lseed, 16390, 100);
    check_rules("long");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0; start = 1'b0; seed = 16'h0000; col_ready = 1'b0;
    test_reset();
    test_fill_stall();
    test_seed_zero();
    test_restart();
    test_reset_mid_run();
    test_long_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
